// File: rtl/crc16_port_arbiter.sv
// Round-robin arbiter that shares one 32-bit/cycle CRC16 (poly 0x8005, init 0xFFFF) between N ingress ports.
// Grants a whole frame at a time, forwards it downstream and reports CRC check / timeout per frame.
module crc16_port_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned PW      = $clog2(N_PORTS),
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_PORTS-1:0]    in_valid_i,
  input  logic [N_PORTS-1:0]    in_sop_i,
  input  logic [N_PORTS-1:0]    in_eop_i,
  input  logic [32*N_PORTS-1:0] in_data_i,
  output logic [N_PORTS-1:0]    in_ready_o,
  output logic                  out_valid_o,
  output logic                  out_sop_o,
  output logic                  out_eop_o,
  output logic [31:0]           out_data_o,
  output logic [PW-1:0]         out_port_o,
  input  logic                  out_ready_i,
  output logic                  res_valid_o,
  output logic [PW-1:0]         res_port_o,
  output logic                  res_ok_o,
  output logic                  res_timeout_o,
  output logic [15:0]           res_crc_o,
  output logic                  busy_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CRC_INIT = 16'hFFFF;
  localparam logic [CW-1:0] CRC_POLY = 16'h8005;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_STREAM = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  // MSB-first CRC16 over one 32-bit word; data[31] enters the register first.
  function automatic logic [CW-1:0] crc16_32bit(input logic [CW-1:0] crc, input logic [DW-1:0] data);
    logic [CW-1:0] c;
    logic          fb;
    c = crc;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[CW-1] ^ data[i];
      c  = {c[CW-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   g_q;
  logic [CW-1:0]   crc_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            err_q;
  logic            first_q;
  logic            cmp_q;
  logic            timeout_q;
  logic            res_valid_q;
  logic [PW-1:0]   res_port_q;
  logic            res_ok_q;
  logic            res_timeout_q;
  logic [CW-1:0]   res_crc_q;
  logic            busy_q;

  logic [DW-1:0]      port_data [N_PORTS];
  logic [N_PORTS-1:0] eligible;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic               stream;
  logic               g_valid;
  logic               g_sop;
  logic               g_eop;
  logic [DW-1:0]      g_data;
  logic               accept;
  logic [CW-1:0]      crc_next;
  logic [TW-1:0]      tmo_inc;
  logic               tmo_hit;
  logic [PW-1:0]      rr_next;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign port_data[gi] = in_data_i[DW*gi +: DW];
  end

  assign eligible = in_valid_i & in_sop_i;

  // First eligible port at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!pick_found && eligible[PW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign stream   = (state_q == S_STREAM);
  assign g_valid  = in_valid_i[g_q];
  assign g_sop    = in_sop_i[g_q];
  assign g_eop    = in_eop_i[g_q];
  assign g_data   = port_data[g_q];
  assign accept   = stream & g_valid & out_ready_i;
  assign crc_next = crc16_32bit(crc_q, g_data);
  assign tmo_inc  = tmo_cnt_q + TW'(1);
  assign tmo_hit  = (tmo_inc == TW'(TIMEOUT - 1));
  assign rr_next  = (g_q == PW'(N_PORTS - 1)) ? '0 : g_q + PW'(1);

  // Granted port is passed straight through while streaming; everything is zero otherwise.
  always_comb begin
    in_ready_o  = '0;
    out_valid_o = 1'b0;
    out_sop_o   = 1'b0;
    out_eop_o   = 1'b0;
    out_data_o  = '0;
    out_port_o  = '0;
    if (stream) begin
      in_ready_o[g_q] = out_ready_i;
      out_valid_o     = g_valid;
      out_sop_o       = g_sop;
      out_eop_o       = g_eop;
      out_data_o      = g_data;
      out_port_o      = g_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      g_q           <= '0;
      crc_q         <= CRC_INIT;
      tmo_cnt_q     <= '0;
      err_q         <= 1'b0;
      first_q       <= 1'b0;
      cmp_q         <= 1'b0;
      timeout_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_port_q    <= '0;
      res_ok_q      <= 1'b0;
      res_timeout_q <= 1'b0;
      res_crc_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          busy_q <= pick_found;
          if (pick_found) begin
            g_q     <= pick_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          crc_q     <= CRC_INIT;
          tmo_cnt_q <= '0;
          err_q     <= 1'b0;
          first_q   <= 1'b1;
          cmp_q     <= 1'b0;
          timeout_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= S_STREAM;
        end
        S_STREAM: begin
          busy_q <= 1'b1;
          // Only an absent word counts toward the timeout; backpressure does not.
          if (g_valid) begin
            tmo_cnt_q <= '0;
          end else if (tmo_hit) begin
            tmo_cnt_q <= tmo_inc;
            timeout_q <= 1'b1;
            state_q   <= S_RESULT;
          end else begin
            tmo_cnt_q <= tmo_inc;
          end
          if (accept) begin
            first_q <= 1'b0;
            if (g_sop && !first_q) err_q <= 1'b1;
            if (g_eop) begin
              cmp_q   <= (crc_q == g_data[CW-1:0]);
              state_q <= S_RESULT;
            end else begin
              crc_q <= crc_next;
            end
          end
        end
        S_RESULT: begin
          res_valid_q   <= 1'b1;
          res_port_q    <= g_q;
          res_crc_q     <= crc_q;
          res_timeout_q <= timeout_q;
          res_ok_q      <= cmp_q & ~err_q & ~timeout_q;
          rr_ptr_q      <= rr_next;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign res_valid_o   = res_valid_q;
  assign res_port_o    = res_port_q;
  assign res_ok_o      = res_ok_q;
  assign res_timeout_o = res_timeout_q;
  assign res_crc_o     = res_crc_q;
  assign busy_o        = busy_q;

endmodule
